baby_loader: RTL and testbench

Program loader for the SSEM store. Sits directly upstream of the store memory and owns its address, data and write-enable ports while active. Accepts a stream of words from the host over a valid/ready handshake and writes them to consecutive store lines. It then reads the lines back, checks the readback against a load-time checksum, and reports done or error. While the loader is busy, the CPU is held off the store.

---
 rtl/baby_loader.sv | 142 ++++++++++++++
 tb/tb_baby_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baby_loader.sv
// Program loader: streams host words into consecutive store lines, reads them back, checks the sum.
// Latency: write lands at end of accept cycle; done pulses count+2 cycles after the last accept.
// Backpressure: in_ready is high for the whole LOAD phase; in_valid gaps simply stretch LOAD.
module baby_loader #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5
) (
   input  logic              clk,
   input  logic              mrst,
   input  logic              start,
   input  logic [AWIDTH-1:0] base,
   input  logic [AWIDTH:0]   count,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_ready,
   output logic [AWIDTH-1:0] store_a,
   output logic [DWIDTH-1:0] store_d,
   output logic              store_we,
   input  logic [DWIDTH-1:0] store_q,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [DWIDTH-1:0] checksum
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_VERIFY = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [AWIDTH-1:0] ONE_A = {{(AWIDTH-1){1'b0}}, 1'b1};
   localparam logic [AWIDTH:0]   ONE_N = {{AWIDTH{1'b0}}, 1'b1};

   logic [2:0]        state;
   logic [AWIDTH-1:0] base_r;
   logic [AWIDTH-1:0] ptr;
   logic [AWIDTH:0]   count_r;
   logic [AWIDTH:0]   n;
   logic [DWIDTH-1:0] rdsum;
   logic [DWIDTH-1:0] rdsum_final;
   // Set on the first VERIFY cycle: store_q then still carries nothing we issued.
   logic              vfirst;
   logic              accept;
   logic              last_n;

   // Abort wins over a simultaneous word, so it gates the write itself.
   assign accept      = (state == S_LOAD) && in_valid && !abort;
   assign last_n      = (n == (count_r - ONE_N));
   assign rdsum_final = rdsum + store_q;

   // Store port and status outputs decode straight from state so reset clears them at once.
   always_comb begin
      in_ready = (state == S_LOAD);
      store_we = accept;
      store_a  = '0;
      store_d  = '0;
      if ((state == S_LOAD) || (state == S_VERIFY)) begin
         store_a = ptr;
      end
      if (accept) begin
         store_d = in_data;
      end
      busy = (state == S_LOAD) || (state == S_VERIFY) || (state == S_DRAIN);
      done = (state == S_DONE);
   end

   // Load / verify sequencer with running write and read sums.
   always_ff @(posedge clk or posedge mrst) begin
      if (mrst) begin
         state    <= S_IDLE;
         base_r   <= '0;
         count_r  <= '0;
         ptr      <= '0;
         n        <= '0;
         checksum <= '0;
         rdsum    <= '0;
         error    <= 1'b0;
         vfirst   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // A zero-length request is dropped without touching any result.
               if (start && (count != '0)) begin
                  base_r   <= base;
                  count_r  <= count;
                  ptr      <= base;
                  n        <= '0;
                  checksum <= '0;
                  rdsum    <= '0;
                  error    <= 1'b0;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  error <= 1'b1;
                  state <= S_DONE;
               end else if (in_valid) begin
                  checksum <= checksum + in_data;
                  if (last_n) begin
                     ptr    <= base_r;
                     n      <= '0;
                     vfirst <= 1'b1;
                     state  <= S_VERIFY;
                  end else begin
                     ptr <= ptr + ONE_A;
                     n   <= n + ONE_N;
                  end
               end
            end
            S_VERIFY: begin
               ptr    <= ptr + ONE_A;
               n      <= n + ONE_N;
               vfirst <= 1'b0;
               if (!vfirst) begin
                  rdsum <= rdsum + store_q;
               end
               if (last_n) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Fold in the last readback and compare here so error is valid alongside done.
               rdsum <= rdsum_final;
               if (rdsum_final != checksum) begin
                  error <= 1'b1;
               end
               state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_baby_loader.sv
// Randomized bench for baby_loader with a behavioural store and a sum/address/timing reference.
// Each load is checked cycle by cycle against expected writes, read addresses and done timing.
// The store model registers reads and can force bit 0 of one readback to emulate corruption.
module tb_baby_loader;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int LINES = 32;

   logic          clk;
   logic          mrst;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   count;
   logic          abort;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [AW-1:0] store_a;
   logic [DW-1:0] store_d;
   logic          store_we;
   logic [DW-1:0] store_q;
   logic          busy;
   logic          done;
   logic          error;
   logic [DW-1:0] checksum;

   logic [DW-1:0] mem [LINES];
   logic [DW-1:0] q_reg;
   logic          corrupt;
   int            we_cnt;
   logic [DW-1:0] wq [LINES];

   int n_cmp;
   int n_bad;

   baby_loader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk      (clk),
      .mrst     (mrst),
      .start    (start),
      .base     (base),
      .count    (count),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .store_a  (store_a),
      .store_d  (store_d),
      .store_we (store_we),
      .store_q  (store_q),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .checksum (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Store: write on we, otherwise registered read; cleared by the shared reset.
   always @(posedge clk or posedge mrst) begin
      if (mrst) begin
         for (int i = 0; i < LINES; i++) mem[i] <= '0;
         q_reg <= '0;
      end else if (store_we) begin
         mem[store_a] <= store_d;
      end else begin
         q_reg <= mem[store_a];
      end
   end

   assign store_q = q_reg | {{(DW-1){1'b0}}, corrupt};

   initial we_cnt = 0;
   always @(posedge clk) if (store_we === 1'b1) we_cnt <= we_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: in_valid held high, 1: every other cycle, 2: random gaps.
   task automatic run_load(input int b, input int cnt, input int mode, input int abort_idx,
                           input int corrupt_idx, input bit chk_err_clr);
      int            acc;
      int            tcyc;
      int            we0;
      int            ab_addr;
      bit            aborted;
      bit            v;
      logic [DW-1:0] sum;
      logic [DW-1:0] old_ab;
      acc = 0; tcyc = 0; aborted = 1'b0; sum = '0;
      ab_addr = (abort_idx >= 0) ? (b + abort_idx) % LINES : 0;
      old_ab  = mem[ab_addr];
      step();
      we0   = we_cnt;
      start = 1'b1; base = AW'(b); count = (AW+1)'(cnt);
      step();
      start = 1'b0; base = AW'($urandom); count = (AW+1)'($urandom);
      check("busy_after_start", 32'(busy), 1);
      check("in_ready_load", 32'(in_ready), 1);
      if (chk_err_clr) check("error_cleared", 32'(error), 0);
      while (acc < cnt && !aborted && tcyc < 2000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (tcyc % 2) == 0;
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data  = v ? wq[acc] : $urandom;
         abort    = v && (acc == abort_idx);
         #1;
         if (abort) begin
            check("abort_no_write", 32'(store_we), 0);
            aborted = 1'b1;
         end else if (v) begin
            check("load_we", 32'(store_we), 1);
            check("load_addr", 32'(store_a), 32'((b + acc) % LINES));
            check("load_data", store_d, wq[acc]);
            sum += wq[acc];
            acc++;
         end else begin
            check("gap_no_write", 32'(store_we), 0);
         end
         step();
         in_valid = 1'b0; abort = 1'b0;
         tcyc++;
      end
      if (tcyc >= 2000) check("load_timeout", 0, 1);
      if (aborted) begin
         check("abort_done", 32'(done), 1);
         check("abort_error", 32'(error), 1);
         check("abort_busy", 32'(busy), 0);
         check("abort_line_kept", mem[ab_addr], old_ab);
         check("abort_writes", 32'(we_cnt - we0), 32'(abort_idx));
         step();
         check("abort_done_1cyc", 32'(done), 0);
         return;
      end
      // Cycles L+1 .. L+cnt: readback issue, one line per cycle.
      for (int i = 0; i < cnt; i++) begin
         corrupt = (corrupt_idx >= 0) && (i == corrupt_idx + 1);
         #1;
         check("verify_we", 32'(store_we), 0);
         check("verify_addr", 32'(store_a), 32'((b + i) % LINES));
         check("verify_busy", 32'(busy), 1);
         if (i == 0) check("verify_in_ready", 32'(in_ready), 0);
         step();
      end
      // Cycle L+cnt+1: drain of the final readback.
      corrupt = (corrupt_idx >= 0) && (corrupt_idx == cnt - 1);
      #1;
      check("drain_busy", 32'(busy), 1);
      check("drain_no_done", 32'(done), 0);
      step();
      corrupt = 1'b0;
      check("done_pulse", 32'(done), 1);
      check("done_busy_low", 32'(busy), 0);
      check("done_error", 32'(error), (corrupt_idx >= 0) ? 1 : 0);
      check("checksum", checksum, sum);
      check("write_count", 32'(we_cnt - we0), 32'(cnt));
      for (int i = 0; i < cnt; i++) check("store_line", mem[(b + i) % LINES], wq[i]);
      step();
      check("done_1cyc", 32'(done), 0);
      check("idle_addr", 32'(store_a), 0);
      check("error_holds", 32'(error), (corrupt_idx >= 0) ? 1 : 0);
   endtask

   initial begin
      bit saw_done;
      int rb;
      int rc;
      n_cmp = 0; n_bad = 0;
      mrst = 1'b1; start = 1'b0; base = '0; count = '0; abort = 1'b0;
      in_valid = 1'b0; in_data = '0; corrupt = 1'b0;
      for (int i = 0; i < LINES; i++) wq[i] = '0;
      #12;
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_we", 32'(store_we), 0);
      check("rst_addr", 32'(store_a), 0);
      check("rst_data", store_d, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_checksum", checksum, 0);
      step();
      mrst = 1'b0;

      // Basic load: 1,2,3,4 at line 0.
      for (int i = 0; i < 4; i++) wq[i] = 32'(i + 1);
      run_load(0, 4, 0, -1, -1, 1'b0);
      check("basic_sum_10", checksum, 32'd10);

      // Wrap-around: lines 30,31,0,1.
      for (int i = 0; i < 4; i++) wq[i] = $urandom;
      run_load(30, 4, 0, -1, -1, 1'b0);

      // Backpressure and checksum overflow.
      wq[0] = 32'hFFFF_FFFF; wq[1] = 32'h0000_0002;
      run_load(5, 2, 1, -1, -1, 1'b0);
      check("overflow_sum", checksum, 32'h0000_0001);

      // Corruption of the third readback, then a clean load clears error.
      for (int i = 0; i < 6; i++) wq[i] = $urandom;
      wq[2] = wq[2] & ~32'h1;
      run_load(10, 6, 0, -1, 2, 1'b0);
      for (int i = 0; i < 3; i++) wq[i] = $urandom;
      run_load(20, 3, 2, -1, -1, 1'b1);

      // Corruption on the very last readback (lands in the drain cycle).
      for (int i = 0; i < 3; i++) wq[i] = $urandom & ~32'h1;
      run_load(7, 3, 0, -1, 2, 1'b0);

      // Abort on the 3rd word of 8.
      for (int i = 0; i < 8; i++) wq[i] = $urandom | 32'h1;
      run_load(0, 8, 0, 2, -1, 1'b0);

      // start with count=0 is ignored.
      step();
      start = 1'b1; count = '0; base = 5'd3;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("cnt0_busy", 32'(busy), 0);
         check("cnt0_in_ready", 32'(in_ready), 0);
         step();
      end

      // Reset in the middle of a load.
      start = 1'b1; base = 5'd3; count = 6'd8;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = 32'h0000_1234;
      step();
      mrst = 1'b1;
      #1;
      check("mrst_in_ready", 32'(in_ready), 0);
      check("mrst_we", 32'(store_we), 0);
      check("mrst_addr", 32'(store_a), 0);
      check("mrst_data", store_d, 0);
      check("mrst_busy", 32'(busy), 0);
      check("mrst_done", 32'(done), 0);
      check("mrst_error", 32'(error), 0);
      check("mrst_checksum", checksum, 0);
      in_valid = 1'b0;
      step();
      mrst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) saw_done = 1'b1;
         step();
      end
      check("mrst_no_done", 32'(saw_done), 0);
      check("mrst_idle_busy", 32'(busy), 0);

      // Full store.
      for (int i = 0; i < LINES; i++) wq[i] = $urandom;
      run_load(int'($urandom_range(0, 31)), 32, 0, -1, -1, 1'b0);

      // Random loads with random gaps.
      for (int r = 0; r < 6; r++) begin
         rb = int'($urandom_range(0, 31));
         rc = int'($urandom_range(1, 32));
         for (int i = 0; i < rc; i++) wq[i] = $urandom;
         run_load(rb, rc, 2, -1, -1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
